// File: rtl/unidad_control_pkg.sv
// Shared types and constants for the unidad_control multi-cycle control unit.
// Covers the opcode and FSM state encodings, the IR field layout, flag indices,
// shifter and mux select codes, and the control word from cu_decode.
package unidad_control_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_LDI  = 4'h2,
        OP_SHF  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_JMP  = 4'h6,
        OP_BR   = 4'h7,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // IR field positions
    localparam int IR_OP_HI   = 15;
    localparam int IR_OP_LO   = 12;
    localparam int IR_DR_HI   = 11;
    localparam int IR_DR_LO   = 10;
    localparam int IR_SA_HI   = 9;
    localparam int IR_SA_LO   = 8;
    localparam int IR_SB_HI   = 7;
    localparam int IR_SB_LO   = 6;
    localparam int IR_FN_HI   = 5;
    localparam int IR_FN_LO   = 2;
    localparam int IR_IMM_HI  = 7;
    localparam int IR_IMM_LO  = 0;
    localparam int IR_CC_HI   = 11;
    localparam int IR_CC_LO   = 10;

    // Flag indices inside the {V,C,N,Z} tag vector
    localparam int TAG_Z = 0;
    localparam int TAG_N = 1;
    localparam int TAG_C = 2;
    localparam int TAG_V = 3;

    // Shifter function codes
    localparam logic [1:0] H_SEL_PASS  = 2'b00;
    localparam logic [1:0] H_SEL_RIGHT = 2'b01;
    localparam logic [1:0] H_SEL_LEFT  = 2'b10;
    localparam logic [1:0] H_SEL_ROT   = 2'b11;

    // Datapath mux selects
    localparam logic MB_REG   = 1'b0;
    localparam logic MB_CONS  = 1'b1;
    localparam logic MD_DATA  = 1'b0;
    localparam logic MD_FBUS  = 1'b1;
    localparam logic MF_SHIFT = 1'b0;
    localparam logic MF_ALU   = 1'b1;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [1:0] dest_sel;
        logic [1:0] h_sel;
        logic [3:0] g_sel;
        logic       mb_sel;
        logic       md_sel;
        logic       mf_sel;
        logic       load_en;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [7:0] imm;
    } ctrl_word_t;

endpackage

// File: rtl/unidad_control_decode.sv
// cu_decode: combinational translation of (FSM state, IR) into the datapath
// control word. Outside DECODE/EXEC/MEM the word is all zero. In MEM the LD
// write strobe is asserted for the whole state; the top gates it with dmem_ack.
module cu_decode
    import unidad_control_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    output ctrl_word_t  cw
);

    opcode_t    op;
    logic       active;
    logic       exec_cycle;
    logic       mem_cycle;
    logic [1:0] dr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [3:0] fn;

    assign op         = opcode_t'(ir[IR_OP_HI:IR_OP_LO]);
    assign dr         = ir[IR_DR_HI:IR_DR_LO];
    assign sa         = ir[IR_SA_HI:IR_SA_LO];
    assign sb         = ir[IR_SB_HI:IR_SB_LO];
    assign fn         = ir[IR_FN_HI:IR_FN_LO];
    assign exec_cycle = (state == S_EXEC);
    assign mem_cycle  = (state == S_MEM);
    assign active     = (state == S_DECODE) || exec_cycle || mem_cycle;

    // Control word per opcode; DECODE shows the same word as EXEC minus the strobe
    always_comb begin
        cw = '0;
        if (active) begin
            case (op)
                OP_ALU: begin
                    cw.a_sel    = sa;
                    cw.b_sel    = sb;
                    cw.g_sel    = fn;
                    cw.mb_sel   = MB_REG;
                    cw.mf_sel   = MF_ALU;
                    cw.md_sel   = MD_FBUS;
                    cw.dest_sel = dr;
                    cw.load_en  = exec_cycle;
                end
                OP_LDI: begin
                    cw.imm      = ir[IR_IMM_HI:IR_IMM_LO];
                    cw.mb_sel   = MB_CONS;
                    cw.h_sel    = H_SEL_PASS;
                    cw.mf_sel   = MF_SHIFT;
                    cw.md_sel   = MD_FBUS;
                    cw.dest_sel = dr;
                    cw.load_en  = exec_cycle;
                end
                OP_SHF: begin
                    cw.b_sel    = sb;
                    cw.mb_sel   = MB_REG;
                    cw.h_sel    = fn[1:0];
                    cw.mf_sel   = MF_SHIFT;
                    cw.md_sel   = MD_FBUS;
                    cw.dest_sel = dr;
                    cw.load_en  = exec_cycle;
                end
                OP_LD: begin
                    cw.a_sel    = sa;
                    cw.b_sel    = sb;
                    cw.mb_sel   = MB_REG;
                    cw.md_sel   = MD_DATA;
                    cw.dest_sel = dr;
                    cw.dmem_rd  = mem_cycle;
                    cw.load_en  = mem_cycle;
                end
                OP_ST: begin
                    cw.a_sel    = sa;
                    cw.b_sel    = sb;
                    cw.mb_sel   = MB_REG;
                    cw.dmem_wr  = mem_cycle;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/unidad_control.sv
// unidad_control: multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer for the
// 4-register datapath. Holds PC, IR and the flag register; the control word
// comes from cu_decode. Optional build macro ILLEGAL_TRAP_EN traps opcodes
// 0x8-0xE into HALT with a sticky illegal_op; otherwise they act as NOP.
module unidad_control
    import unidad_control_pkg::*;
#(
    parameter int M        = 8,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            dmem_rd,
    output logic            dmem_wr,
    input  logic            dmem_ack,
    input  logic [3:0]      Tags,
    output logic [1:0]      A_sel,
    output logic [1:0]      B_sel,
    output logic [1:0]      Dest_sel,
    output logic [1:0]      H_sel,
    output logic [3:0]      G_sel,
    output logic            MB_sel,
    output logic            MD_sel,
    output logic            MF_sel,
    output logic            Load_en,
    output logic [M-1:0]    Cons_IN,
    output logic            halted,
    output logic            illegal_op
);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [3:0]      flags_q;
    logic            run_q;     // low during reset and the first cycle after release
    ctrl_word_t      cw;
    opcode_t         op;
    logic [1:0]      cond;
    logic [PC_W-1:0] imm_pc;

    assign op     = opcode_t'(ir_q[IR_OP_HI:IR_OP_LO]);
    assign cond   = ir_q[IR_CC_HI:IR_CC_LO];
    assign imm_pc = PC_W'(ir_q[IR_IMM_HI:IR_IMM_LO]);

`ifdef ILLEGAL_TRAP_EN
    logic is_undef;
    logic illegal_q;
    assign is_undef = (ir_q[IR_OP_HI:IR_OP_LO] >= 4'h8) && (ir_q[IR_OP_HI:IR_OP_LO] <= 4'hE);
`endif

    // Main sequencer: state, PC, IR and flag updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_W'(RESET_PC);
            ir_q    <= '0;
            flags_q <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_FETCH: begin
                    if (run_q && imem_ack) begin
                        ir_q    <= imem_data;
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= S_EXEC;
                S_EXEC: begin
                    state_q <= S_FETCH;
                    case (op)
                        OP_ALU:  flags_q <= Tags;
                        OP_LD,
                        OP_ST:   state_q <= S_MEM;
                        OP_JMP:  pc_q    <= imm_pc;
                        OP_BR:   if (flags_q[cond]) pc_q <= imm_pc;
                        OP_HALT: state_q <= S_HALT;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            if (is_undef) state_q <= S_HALT;
`endif
                        end
                    endcase
                end
                S_MEM:   if (dmem_ack) state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky record of an undefined opcode reaching EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (state_q == S_EXEC && is_undef)
            illegal_q <= 1'b1;
    end
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    cu_decode u_decode (
        .state (state_q),
        .ir    (ir_q),
        .cw    (cw)
    );

    assign imem_addr = pc_q;
    assign imem_req  = run_q && (state_q == S_FETCH);
    assign dmem_rd   = cw.dmem_rd;
    assign dmem_wr   = cw.dmem_wr;
    assign A_sel     = cw.a_sel;
    assign B_sel     = cw.b_sel;
    assign Dest_sel  = cw.dest_sel;
    assign H_sel     = cw.h_sel;
    assign G_sel     = cw.g_sel;
    assign MB_sel    = cw.mb_sel;
    assign MD_sel    = cw.md_sel;
    assign MF_sel    = cw.mf_sel;
    // A load from memory writes back only in the cycle the data arrives
    assign Load_en   = cw.load_en && ((state_q != S_MEM) || dmem_ack);
    assign Cons_IN   = M'(cw.imm);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_unidad_control.sv
// Testbench for unidad_control: directed vector table, hand-written reset /
// halt / illegal-op sequences, and random instructions checked against an
// instruction-level reference model.
module tb_unidad_control;

    localparam int M    = 8;
    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack = 1'b0;
    logic [15:0]     imem_data = '0;
    logic            dmem_rd;
    logic            dmem_wr;
    logic            dmem_ack = 1'b0;
    logic [3:0]      Tags = '0;
    logic [1:0]      A_sel, B_sel, Dest_sel, H_sel;
    logic [3:0]      G_sel;
    logic            MB_sel, MD_sel, MF_sel, Load_en;
    logic [M-1:0]    Cons_IN;
    logic            halted;
    logic            illegal_op;

    always #5 clk = ~clk;

    unidad_control #(.M(M), .PC_W(PC_W), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ack(dmem_ack), .Tags(Tags),
        .A_sel(A_sel), .B_sel(B_sel), .Dest_sel(Dest_sel), .H_sel(H_sel), .G_sel(G_sel),
        .MB_sel(MB_sel), .MD_sel(MD_sel), .MF_sel(MF_sel), .Load_en(Load_en),
        .Cons_IN(Cons_IN), .halted(halted), .illegal_op(illegal_op)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mpc;
    logic [3:0] mflags;

    logic [23:0] cw_now;
    assign cw_now = {A_sel, B_sel, Dest_sel, H_sel, G_sel, MB_sel, MD_sel, MF_sel, Load_en, Cons_IN};

    localparam logic [23:0] LE_BIT = 24'h000100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pk(int a, int b, int d, int h, int g,
                                        int mb, int md, int mf, int le, int cons);
        return {2'(a), 2'(b), 2'(d), 2'(h), 4'(g), 1'(mb), 1'(md), 1'(mf), 1'(le), 8'(cons)};
    endfunction

    // Reference: control word expected in EXEC, from the instruction set rules
    function automatic logic [23:0] model_ctrl(logic [15:0] ins);
        int op, dr, sa, sb, fn, imm;
        op  = int'(ins) / 4096;
        dr  = (int'(ins) / 1024) % 4;
        sa  = (int'(ins) / 256) % 4;
        sb  = (int'(ins) / 64) % 4;
        fn  = (int'(ins) / 4) % 16;
        imm = int'(ins) % 256;
        case (op)
            1: return pk(sa, sb, dr, 0, fn, 0, 1, 1, 1, 0);
            2: return pk(0, 0, dr, 0, 0, 1, 1, 0, 1, imm);
            3: return pk(0, sb, dr, fn % 4, 0, 0, 1, 0, 1, 0);
            4: return pk(sa, sb, dr, 0, 0, 0, 0, 0, 0, 0);
            5: return pk(sa, sb, 0, 0, 0, 0, 0, 0, 0, 0);
            default: return 24'h0;
        endcase
    endfunction

    // Reference: address of the next fetch
    function automatic logic [7:0] model_next(logic [15:0] ins, logic [7:0] pc_now, logic [3:0] flags);
        int op, cc, imm;
        logic [7:0] seq;
        op  = int'(ins) / 4096;
        cc  = (int'(ins) / 1024) % 4;
        imm = int'(ins) % 256;
        seq = 8'((int'(pc_now) + 1) % 256);
        if (op == 6) return 8'(imm);
        if (op == 7 && flags[cc]) return 8'(imm);
        return seq;
    endfunction

    // Runs one non-halting instruction from a FETCH sample point to the next one
    task automatic run_instr(input logic [15:0] ins, input logic [3:0] tg, input int iw, input int dw,
                             input logic [23:0] exp_cw, input logic [7:0] exp_next, input string tag);
        int op;
        op = int'(ins) / 4096;
        for (int i = 0; i < iw; i++) begin
            dmem_ack = 1'($urandom % 2);
            #1;
            chk({tag, "_fetch_hold"}, {imem_req, imem_addr, Load_en}, {1'b1, mpc, 1'b0});
            step();
        end
        dmem_ack  = 1'b0;
        imem_ack  = 1'b1;
        imem_data = ins;
        step();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        Tags      = tg;
        #1;
        chk({tag, "_decode_cw"}, cw_now, exp_cw & ~LE_BIT);
        chk({tag, "_decode_req"}, {imem_req, dmem_rd, dmem_wr}, 3'b000);
        step();
        chk({tag, "_exec_cw"}, cw_now, exp_cw);
        step();
        if (op == 4 || op == 5) begin
            for (int i = 0; i < dw; i++) begin
                imem_ack = 1'($urandom % 2);
                #1;
                chk({tag, "_mem_wait"}, {dmem_rd, dmem_wr, Load_en, imem_req},
                    {op == 4, op == 5, 1'b0, 1'b0});
                step();
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b1;
            #1;
            chk({tag, "_mem_ack_cw"}, cw_now, (op == 4) ? (exp_cw | LE_BIT) : exp_cw);
            chk({tag, "_mem_ack_req"}, {dmem_rd, dmem_wr}, {op == 4, op == 5});
            step();
            dmem_ack = 1'b0;
        end
        #1;
        chk({tag, "_next_fetch"}, {imem_req, imem_addr, Load_en, dmem_rd, dmem_wr},
            {1'b1, exp_next, 3'b000});
        $display("instr %h tags %b -> next pc %h", ins, tg, exp_next);
        mpc = exp_next;
        if (op == 1) mflags = tg;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {imem_req, dmem_rd, dmem_wr, Load_en, halted, illegal_op, imem_addr}, 32'h0);
        chk("reset_cw", cw_now, 24'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("reset_release_req", imem_req, 1'b0);
        step();
        #1;
        chk("reset_then_req", {imem_req, imem_addr}, {1'b1, 8'h00});
        mpc    = 8'h00;
        mflags = 4'h0;
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  tg;
        int          iw;
        int          dw;
        logic [23:0] cw;
        logic [7:0]  nxt;
    } vec_t;

    vec_t vt[14];

    initial begin
        logic [3:0]  opr;
        logic [15:0] ins;
        logic [3:0]  tg;
        logic [7:0]  nxt;

        vt[0]  = '{16'h19D4, 4'b0001, 0, 0, pk(1, 3, 2, 0, 5, 0, 1, 1, 1, 0),    8'h01};
        vt[1]  = '{16'h24A5, 4'b0000, 1, 0, pk(0, 0, 1, 0, 0, 1, 1, 0, 1, 'hA5), 8'h02};
        vt[2]  = '{16'h7040, 4'b0000, 0, 0, 24'h0,                             8'h40};
        vt[3]  = '{16'h4600, 4'b0000, 2, 3, pk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0),    8'h41};
        vt[4]  = '{16'h19D4, 4'b0000, 0, 0, pk(1, 3, 2, 0, 5, 0, 1, 1, 1, 0),    8'h42};
        vt[5]  = '{16'h7040, 4'b0000, 0, 0, 24'h0,                             8'h43};
        vt[6]  = '{16'h5E40, 4'b0000, 0, 0, pk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0),    8'h44};
        vt[7]  = '{16'h3C8B, 4'b0000, 0, 0, pk(0, 2, 3, 2, 0, 0, 1, 0, 1, 0),    8'h45};
        vt[8]  = '{16'h60F0, 4'b0000, 0, 0, 24'h0,                             8'hF0};
        vt[9]  = '{16'h0000, 4'b0000, 3, 0, 24'h0,                             8'hF1};
        vt[10] = '{16'h19D4, 4'b0010, 0, 0, pk(1, 3, 2, 0, 5, 0, 1, 1, 1, 0),    8'hF2};
        vt[11] = '{16'h7440, 4'b0000, 0, 0, 24'h0,                             8'h40};
        vt[12] = '{16'h60FF, 4'b0000, 0, 0, 24'h0,                             8'hFF};
        vt[13] = '{16'h0000, 4'b0000, 0, 0, 24'h0,                             8'h00};

        mpc    = 8'h00;
        mflags = 4'h0;

        // Reset while the core would be fetching
        step();
        do_reset();

        // Directed table
        for (int i = 0; i < 14; i++)
            run_instr(vt[i].ins, vt[i].tg, vt[i].iw, vt[i].dw, vt[i].cw, vt[i].nxt, $sformatf("vec%0d", i));

        // Reset asserted while a load waits for memory
        imem_ack  = 1'b1;
        imem_data = 16'h4600;
        step();
        imem_ack = 1'b0;
        step();
        step();
        #1;
        chk("midreset_pre_rd", dmem_rd, 1'b1);
        rst_n    = 1'b0;
        dmem_ack = 1'b1;
        #1;
        chk("midreset_abort", {dmem_rd, imem_req, Load_en, imem_addr}, 32'h0);
        step();
        dmem_ack = 1'b0;
        rst_n    = 1'b1;
        step();
        #1;
        chk("midreset_refetch", {imem_req, imem_addr}, {1'b1, 8'h00});
        mpc    = 8'h00;
        mflags = 4'h0;

        // Random instruction stream against the reference model
        for (int n = 0; n < 80; n++) begin
            opr = 4'($urandom_range(0, 7));
            ins = {opr, 12'($urandom)};
            tg  = 4'($urandom);
            nxt = model_next(ins, mpc, mflags);
            run_instr(ins, tg, $urandom_range(0, 3), $urandom_range(0, 3),
                      model_ctrl(ins), nxt, $sformatf("rnd%0d", n));
        end

        // Undefined opcode
`ifdef ILLEGAL_TRAP_EN
        imem_ack  = 1'b1;
        imem_data = 16'h8000;
        step();
        imem_ack = 1'b0;
        step();
        step();
        #1;
        chk("illegal_trap", {halted, illegal_op, imem_req, Load_en}, 4'b1100);
        step();
        do_reset();
        chk("illegal_cleared", illegal_op, 1'b0);
`else
        run_instr(16'h8000, 4'h0, 0, 0, 24'h0, 8'(mpc + 8'd1), "undef_nop");
        chk("illegal_tied", illegal_op, 1'b0);
`endif

        // HALT: no further fetches, stray acks ignored
        imem_ack  = 1'b1;
        imem_data = 16'hF000;
        step();
        imem_ack = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            chk($sformatf("halt_hold%0d", i), {halted, imem_req, dmem_rd, dmem_wr, Load_en}, 5'b10000);
            step();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        $display("halt sequence done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
